// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between vga_timing_gen and its consumers
interface vga_timing_gen_if;
   logic       pixel_clk;
   logic       pixel_en;
   logic       hs;
   logic       vs;
   logic       blank;
   logic       sync;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       frame_start;
   logic       line_start;
   logic [7:0] frame_count;

   modport master (
      output pixel_clk, pixel_en, hs, vs, blank, sync,
      output DrawX, DrawY, frame_start, line_start, frame_count
   );

   modport slave (
      input pixel_clk, pixel_en, hs, vs, blank, sync,
      input DrawX, DrawY, frame_start, line_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel enable, X/Y counters, syncs, blank, strobes
// Optional frame counter enabled by defining VGA_TIMING_FRAME_COUNTER_EN.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic             Clk,
   input  logic             Reset,
   vga_timing_gen_if.master vga
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic       phase;
   logic [9:0] x_q, y_q;
   logic [9:0] x_nxt, y_nxt;
   logic       h_wrap, v_wrap;
   logic       hs_q, vs_q, blank_q;
   logic       line_q, frame_q;

   // Counters only move on the phase-1 cycle, i.e. when pixel_en is high.
   always_comb begin
      x_nxt  = x_q;
      y_nxt  = y_q;
      h_wrap = phase && (x_q == H_LAST);
      v_wrap = h_wrap && (y_q == V_LAST);
      if (phase) begin
         if (x_q == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == V_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_nxt = x_q + 10'd1;
         end
      end
   end

   // Decodes use next-state counters so they land on the same edge as DrawX/DrawY.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         phase   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b0;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         phase   <= ~phase;
         x_q     <= x_nxt;
         y_q     <= y_nxt;
         hs_q    <= !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
         vs_q    <= !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));
         blank_q <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
         line_q  <= h_wrap;
         frame_q <= v_wrap;
      end
   end

`ifdef VGA_TIMING_FRAME_COUNTER_EN
   logic [7:0] frame_cnt_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_cnt_q <= '0;
      end else if (v_wrap) begin
         frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   assign vga.frame_count = frame_cnt_q;
`else
   assign vga.frame_count = 8'h00;
`endif

   assign vga.pixel_clk   = phase;
   assign vga.pixel_en    = phase;
   assign vga.hs          = hs_q;
   assign vga.vs          = vs_q;
   assign vga.blank       = blank_q;
   assign vga.sync        = 1'b0;
   assign vga.DrawX       = x_q;
   assign vga.DrawY       = y_q;
   assign vga.line_start  = line_q;
   assign vga.frame_start = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (default and reduced raster)
module tb_vga_timing_gen;
   localparam int SH_V = 8, SH_F = 2, SH_S = 2, SH_B = 2;
   localparam int SV_V = 4, SV_F = 1, SV_S = 1, SV_B = 1;
   localparam int S_FRAME_CLKS = 2 * (SH_V + SH_F + SH_S + SH_B) * (SV_V + SV_F + SV_S + SV_B);

   typedef struct packed {
      logic       pclk;
      logic       pen;
      logic       hs;
      logic       vs;
      logic       blank;
      logic       sync;
      logic [9:0] x;
      logic [9:0] y;
      logic       fs;
      logic       ls;
      logic [7:0] fc;
   } vga_t;

   typedef struct {
      logic rst;
      int   x;
      int   y;
      logic hs;
      logic blank;
      logic pen;
   } vec_t;

   logic   Clk = 1'b0;
   logic   Reset = 1'b1;
   logic   chk_en = 1'b0;
   longint k = 0;
   longint cyc = 0;
   int     vectors = 0;
   int     miscompares = 0;

   vga_timing_gen_if d_if ();
   vga_timing_gen_if s_if ();

   vga_timing_gen u_dflt (
      .Clk   (Clk),
      .Reset (Reset),
      .vga   (d_if.master)
   );

   vga_timing_gen #(
      .H_VISIBLE (SH_V), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
      .V_VISIBLE (SV_V), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B)
   ) u_small (
      .Clk   (Clk),
      .Reset (Reset),
      .vga   (s_if.master)
   );

   always #5 Clk = ~Clk;

   // k = Clk edges since Reset was last released; the whole raster follows from it.
   always @(posedge Clk) begin
      cyc <= cyc + 1;
      k   <= Reset ? 64'sd0 : k + 1;
   end

   function automatic vga_t ref_pixel(longint kk, int hv, int hf, int hsw, int hb,
                                      int vv, int vf, int vsw, int vb);
      vga_t   e;
      longint n, x, y, fr;
      int     ht, vt;
      e    = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      if (kk == 0) return e;
      ht      = hv + hf + hsw + hb;
      vt      = vv + vf + vsw + vb;
      n       = kk / 2;
      x       = n % ht;
      y       = (n / ht) % vt;
      fr      = n / (ht * vt);
      e.pclk  = (kk % 2) == 1;
      e.pen   = (kk % 2) == 1;
      e.hs    = !(x >= hv + hf && x < hv + hf + hsw);
      e.vs    = !(y >= vv + vf && y < vv + vf + vsw);
      e.blank = (x < hv) && (y < vv);
      e.x     = 10'(x);
      e.y     = 10'(y);
      e.ls    = ((kk % 2) == 0) && (x == 0);
      e.fs    = ((kk % 2) == 0) && (x == 0) && (y == 0);
`ifdef VGA_TIMING_FRAME_COUNTER_EN
      e.fc    = 8'(fr % 256);
`else
      e.fc    = 8'h00;
`endif
      return e;
   endfunction

   vga_t d_act, s_act;
   assign d_act = {d_if.pixel_clk, d_if.pixel_en, d_if.hs, d_if.vs, d_if.blank, d_if.sync,
                   d_if.DrawX, d_if.DrawY, d_if.frame_start, d_if.line_start, d_if.frame_count};
   assign s_act = {s_if.pixel_clk, s_if.pixel_en, s_if.hs, s_if.vs, s_if.blank, s_if.sync,
                   s_if.DrawX, s_if.DrawY, s_if.frame_start, s_if.line_start, s_if.frame_count};

   task automatic check_vec(string name, vga_t act, vga_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s k=%0d act=%h exp=%h", name, k, act, exp);
      end
   endtask

   task automatic check_val(string name, longint act, longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (chk_en) begin
         check_vec("model_dflt", d_act, ref_pixel(k, 640, 16, 96, 48, 480, 10, 2, 33));
         check_vec("model_small", s_act,
                   ref_pixel(k, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B));
      end
   end

   initial begin
      vec_t   tbl[8];
      longint t0;
      int     y0, pulses, spurious;
      logic   got;

      tbl[0] = '{1'b1, 0, 0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 0, 0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 0, 0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1};
      tbl[6] = '{1'b0, 2, 0, 1'b1, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 2, 0, 1'b1, 1'b1, 1'b1};

      @(negedge Clk);
      chk_en = 1'b1;

      for (int i = 0; i < 8; i++) begin
         Reset = tbl[i].rst;
         @(negedge Clk);
         check_val($sformatf("tbl%0d_x", i), d_if.DrawX, tbl[i].x);
         check_val($sformatf("tbl%0d_y", i), d_if.DrawY, tbl[i].y);
         check_val($sformatf("tbl%0d_hs", i), d_if.hs, tbl[i].hs);
         check_val($sformatf("tbl%0d_blank", i), d_if.blank, tbl[i].blank);
         check_val($sformatf("tbl%0d_pen", i), d_if.pixel_en, tbl[i].pen);
      end

      for (int i = 0; i < 4000 && !d_if.line_start; i++) @(negedge Clk);
      check_val("first_line_start_seen", d_if.line_start, 1);
      t0 = cyc;
      y0 = d_if.DrawY;
      for (int i = 0; i < 2000 && d_if.blank; i++) @(negedge Clk);
      check_val("blank_fall_x", d_if.DrawX, 640);
      for (int i = 0; i < 2000 && d_if.hs; i++) @(negedge Clk);
      check_val("hs_fall_x", d_if.DrawX, 656);
      for (int i = 0; i < 2000 && !d_if.hs; i++) @(negedge Clk);
      check_val("hs_rise_x", d_if.DrawX, 752);
      for (int i = 0; i < 2000 && !d_if.line_start; i++) @(negedge Clk);
      check_val("line_period", cyc - t0, 1600);
      check_val("line_y_step", d_if.DrawY, y0 + 1);

      for (int i = 0; i < 2 * S_FRAME_CLKS && !s_if.frame_start; i++) @(negedge Clk);
      t0 = cyc;
      @(negedge Clk);
      for (int i = 0; i < 2 * S_FRAME_CLKS && !s_if.frame_start; i++) @(negedge Clk);
      check_val("small_frame_period", cyc - t0, S_FRAME_CLKS);
      check_val("small_fs_with_ls", s_if.line_start, 1);

      for (int i = 0; i < 2 * S_FRAME_CLKS && !(s_if.DrawX == 5 && s_if.DrawY == 3); i++)
         @(negedge Clk);
      check_val("midframe_pos_reached", s_if.DrawY, 3);
      Reset = 1'b1;
      @(negedge Clk);
      check_val("midreset_x", s_if.DrawX, 0);
      check_val("midreset_y", s_if.DrawY, 0);
      check_val("midreset_pen", s_if.pixel_en, 0);
      check_val("midreset_dflt_x", d_if.DrawX, 0);
      Reset = 1'b0;
      spurious = 0;
      for (int i = 0; i < S_FRAME_CLKS - 2; i++) begin
         @(negedge Clk);
         if (s_if.frame_start) spurious++;
      end
      check_val("no_spurious_frame_start", spurious, 0);

      for (int i = 0; i < 15; i++) begin
         repeat ($urandom_range(1, 500)) @(negedge Clk);
         Reset = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge Clk);
         Reset = 1'b0;
      end

      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      pulses = 0;
      got    = 1'b1;
      while (pulses < 257 && got) begin
         got = 1'b0;
         for (int i = 0; i < S_FRAME_CLKS + 20 && !got; i++) begin
            @(negedge Clk);
            got = s_if.frame_start;
         end
         if (got) begin
            pulses++;
`ifdef VGA_TIMING_FRAME_COUNTER_EN
            if (pulses == 255) check_val("fc_after_255", s_if.frame_count, 255);
            if (pulses == 256) check_val("fc_after_256", s_if.frame_count, 0);
            if (pulses == 257) check_val("fc_after_257", s_if.frame_count, 1);
`else
            if (pulses >= 255) check_val("fc_tied_zero", s_if.frame_count, 0);
`endif
         end
      end
      check_val("frame_pulses_seen", pulses, 257);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
